// File: rtl/alu_mutation_sweep_ctrl.sv
// Mutation-test sequencer: walks every {op, a, b} vector through a golden and a mutant ALU,
// counts result/zero-flag mismatches and captures the first failing vector.
module alu_mutation_sweep_ctrl #(
    parameter int W     = 4,
    parameter int OPW   = 3,
    parameter int CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    output logic [W-1:0]         alu_a_o,
    output logic [W-1:0]         alu_b_o,
    output logic [OPW-1:0]       alu_op_o,
    input  logic [W-1:0]         ref_result_i,
    input  logic                 ref_zero_i,
    input  logic [W-1:0]         dut_result_i,
    input  logic                 dut_zero_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 killed_o,
    output logic [CNT_W-1:0]     mismatch_count_o,
    output logic                 first_fail_valid_o,
    output logic [OPW+2*W-1:0]   first_fail_vec_o
);

    localparam int N = OPW + 2 * W;
    localparam logic [N-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [N-1:0]       idx_q, idx_d;
    logic [N-1:0]       stim_q, stim_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ffv_q, ffv_d;
    logic [N-1:0]       ffvec_q, ffvec_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               killed_q, killed_d;
    logic               mismatch;

    assign mismatch = (ref_result_i != dut_result_i) || (ref_zero_i != dut_zero_i);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        stim_d   = stim_q;
        cnt_d    = cnt_q;
        ffv_d    = ffv_q;
        ffvec_d  = ffvec_q;
        case (state_q)
            S_RUN: begin
                // The compare for the vector on alu_* is recorded even on abort or the last vector.
                if (mismatch) begin
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = stim_q;
                    end
                end
                if (abort_i) begin
                    state_d = S_IDLE;
                    stim_d  = '0;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    stim_d  = '0;
                end else begin
                    idx_d  = idx_q + 1'b1;
                    stim_d = idx_q + 1'b1;
                end
            end
            default: begin
                if (start_i && !abort_i) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    stim_d  = '0;
                    cnt_d   = '0;
                    ffv_d   = 1'b0;
                    ffvec_d = '0;
                end
            end
        endcase
        busy_d   = (state_d == S_RUN);
        done_d   = (state_d == S_DONE);
        killed_d = (state_d == S_DONE) && (cnt_d != '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            stim_q   <= '0;
            cnt_q    <= '0;
            ffv_q    <= 1'b0;
            ffvec_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            killed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            stim_q   <= stim_d;
            cnt_q    <= cnt_d;
            ffv_q    <= ffv_d;
            ffvec_q  <= ffvec_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            killed_q <= killed_d;
        end
    end

    // Stimulus index is packed {op, a, b}: b toggles fastest.
    assign alu_op_o           = stim_q[N-1 -: OPW];
    assign alu_a_o            = stim_q[2*W-1 -: W];
    assign alu_b_o            = stim_q[W-1:0];
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign killed_o           = killed_q;
    assign mismatch_count_o   = cnt_q;
    assign first_fail_valid_o = ffv_q;
    assign first_fail_vec_o   = ffvec_q;

endmodule

// File: tb/tb_alu_mutation_sweep_ctrl.sv
// Directed bench: golden 4-bit ALU model against tied, bus-order-mutant and inverted-result DUTs.
module tb_alu_mutation_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    int          mode = 0;   // 0: tied, 1: A-bus permuted mutant, 2: inverted result

    logic [3:0]  alu_a, alu_b, ref_res, dut_res;
    logic [2:0]  alu_op;
    logic        ref_z, dut_z;
    logic        busy, done, killed, ffv;
    logic [15:0] cnt;
    logic [10:0] ffvec;

    logic [3:0]  a8, b8, ref_res8, dut_res8;
    logic [2:0]  op8;
    logic        ref_z8, dut_z8, busy8, done8, killed8, ffv8;
    logic [7:0]  cnt8;
    logic [10:0] ffvec8;

    int checks = 0;
    int failures = 0;
    int cyc;

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return a << 1;
            default: return a >> 1;
        endcase
    endfunction

    // Returns {zero, result} of the DUT-side ALU for the selected mode.
    function automatic logic [4:0] dut_alu(input int m, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic       z;
        r = ref_alu(op, a, b);
        z = (r == 4'd0);
        if (m == 1) begin
            r = ref_alu(op, {a[0], a[3], a[1], a[2]}, b);
            z = (r == 4'd0);
        end else if (m == 2) begin
            r = ~r;
        end
        return {z, r};
    endfunction

    function automatic int model_count(input int m, input int last);
        int n;
        logic [10:0] v;
        logic [3:0]  r;
        n = 0;
        for (int i = 0; i <= last; i++) begin
            v = i[10:0];
            r = ref_alu(v[10:8], v[7:4], v[3:0]);
            if ({(r == 4'd0), r} != dut_alu(m, v[10:8], v[7:4], v[3:0])) n++;
        end
        return n;
    endfunction

    always_comb begin
        ref_res = ref_alu(alu_op, alu_a, alu_b);
        ref_z   = (ref_res == 4'd0);
        {dut_z, dut_res} = dut_alu(mode, alu_op, alu_a, alu_b);
        ref_res8 = ref_alu(op8, a8, b8);
        ref_z8   = (ref_res8 == 4'd0);
        {dut_z8, dut_res8} = dut_alu(mode, op8, a8, b8);
    end

    alu_mutation_sweep_ctrl #(.W(4), .OPW(3), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
        .ref_result_i(ref_res), .ref_zero_i(ref_z),
        .dut_result_i(dut_res), .dut_zero_i(dut_z),
        .busy_o(busy), .done_o(done), .killed_o(killed),
        .mismatch_count_o(cnt), .first_fail_valid_o(ffv), .first_fail_vec_o(ffvec)
    );

    alu_mutation_sweep_ctrl #(.W(4), .OPW(3), .CNT_W(8)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .alu_a_o(a8), .alu_b_o(b8), .alu_op_o(op8),
        .ref_result_i(ref_res8), .ref_zero_i(ref_z8),
        .dut_result_i(dut_res8), .dut_zero_i(dut_z8),
        .busy_o(busy8), .done_o(done8), .killed_o(killed8),
        .mismatch_count_o(cnt8), .first_fail_valid_o(ffv8), .first_fail_vec_o(ffvec8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_alu"}, {21'd0, alu_op, alu_a, alu_b}, 32'd0);
    endtask

    // Pulses start, then follows the sweep one vector per cycle until busy drops.
    task automatic do_sweep(input int abort_at, input int start_at, output int cycles);
        cycles = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (busy === 1'b1 && cycles < 5000) begin
            if (cycles == 0) begin
                chk("start_clr_cnt", {16'd0, cnt}, 32'd0);
                chk("start_clr_ffv", {31'd0, ffv}, 32'd0);
                chk("start_done_low", {31'd0, done}, 32'd0);
            end
            if (cycles == 17) begin
                chk("stim_idx17", {21'd0, alu_op, alu_a, alu_b}, 32'h011);
            end
            start = (cycles == start_at);
            abort = (cycles == abort_at);
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        $display("sweep mode=%0d cycles=%0d count=%0d killed=%0d ffv=%0d ffvec=%03h",
                 mode, cycles, cnt, killed, ffv, ffvec);
    endtask

    initial begin
        // Reset state
        #12;
        chk_idle_outputs("reset");
        chk("reset_cnt", {16'd0, cnt}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("post_reset");
        chk("post_reset_killed", {31'd0, killed}, 32'd0);

        // Tied DUT, with a stray start mid-sweep that must be ignored
        mode = 0;
        do_sweep(-1, 500, cyc);
        chk("tied_cycles", cyc, 32'd2048);
        chk("tied_done", {31'd0, done}, 32'd1);
        chk("tied_cnt", {16'd0, cnt}, 32'd0);
        chk("tied_killed", {31'd0, killed}, 32'd0);
        chk("tied_ffv", {31'd0, ffv}, 32'd0);
        chk("tied_alu_zero", {21'd0, alu_op, alu_a, alu_b}, 32'd0);

        // Bus-order mutant
        mode = 1;
        do_sweep(-1, -1, cyc);
        chk("mut_cycles", cyc, 32'd2048);
        chk("mut_killed", {31'd0, killed}, 32'd1);
        chk("mut_ffv", {31'd0, ffv}, 32'd1);
        chk("mut_ffvec", {21'd0, ffvec}, 32'h010);
        chk("mut_cnt", {16'd0, cnt}, model_count(1, 2047));

        // Inverted result: every vector fails; 8-bit counter saturates
        mode = 2;
        do_sweep(-1, -1, cyc);
        chk("inv_cnt", {16'd0, cnt}, 32'd2048);
        chk("inv_killed", {31'd0, killed}, 32'd1);
        chk("inv_ffvec", {21'd0, ffvec}, 32'd0);
        chk("inv_ffv", {31'd0, ffv}, 32'd1);
        chk("inv_cnt8_sat", {24'd0, cnt8}, 32'd255);
        chk("inv_killed8", {31'd0, killed8}, 32'd1);

        // Abort on RUN cycle 100 with the mutant attached
        mode = 1;
        do_sweep(100, -1, cyc);
        chk("abort_cycles", cyc, 32'd101);
        chk_idle_outputs("abort");
        chk("abort_killed", {31'd0, killed}, 32'd0);
        chk("abort_cnt_held", {16'd0, cnt}, model_count(1, 100));
        chk("abort_ffvec_held", {21'd0, ffvec}, 32'h010);
        @(negedge clk);
        chk("abort_still_idle", {31'd0, busy}, 32'd0);
        mode = 0;
        do_sweep(-1, -1, cyc);
        chk("restart_cycles", cyc, 32'd2048);
        chk("restart_cnt", {16'd0, cnt}, 32'd0);

        // Asynchronous reset mid-RUN
        mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (50) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        chk("async_rst_cnt", {16'd0, cnt}, 32'd0);
        chk("async_rst_ffv", {31'd0, ffv}, 32'd0);
        chk("async_rst_ffvec", {21'd0, ffvec}, 32'd0);
        chk("async_rst_killed", {31'd0, killed}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_outputs("after_rst");

        // start and abort together in IDLE: no sweep
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk_idle_outputs("start_abort");
        @(negedge clk);
        chk("start_abort_busy2", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
